// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the memory access controller
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    DONE       = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Highest populated RAM word; used only by the optional address range check
  localparam int unsigned MEM_TOP = 32'h0000_00FF;

  localparam int READ_LATENCY_DEF  = 2;
  localparam int WRITE_LATENCY_DEF = 1;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - loadable down-counter with zero flag for access latency
module mem_wait_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload wins over decrement; counting stops at zero instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MAR/MDR to synchronous RAM sequencer; optional MEM_CTRL_ADDR_RANGE_CHECK_EN
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 9,
  parameter int READ_LATENCY  = READ_LATENCY_DEF,
  parameter int WRITE_LATENCY = WRITE_LATENCY_DEF
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] mar_addr,
  input  logic [DATA_WIDTH-1:0] mdr_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mdr_load,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  fault
);

  localparam int MAX_LAT = max_lat(READ_LATENCY, WRITE_LATENCY);
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ram_re_q;
  logic                  ram_we_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  mdr_load_q;

  logic                  accept;
  op_t                   req_op;
  logic                  addr_bad;
  logic [CNT_W-1:0]      cnt_load_val;
  logic                  cnt_dec;
  logic                  cnt_zero;

  // Read has priority when both requests are raised together
  assign accept       = (state_q == IDLE) && (req_read || req_write);
  assign req_op       = req_read ? OP_READ : OP_WRITE;
  assign cnt_load_val = (req_op == OP_READ) ? CNT_W'(READ_LATENCY - 1)
                                            : CNT_W'(WRITE_LATENCY - 1);
  assign cnt_dec      = (state_q == READ_WAIT) || (state_q == WRITE_WAIT);

`ifdef MEM_CTRL_ADDR_RANGE_CHECK_EN
  logic fault_q;

  assign addr_bad = (32'(mar_addr) > MEM_TOP);

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      fault_q <= 1'b0;
    end else if (accept && addr_bad) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign addr_bad = 1'b0;
  assign fault    = 1'b0;
`endif

  mem_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .clock    (clock),
    .clear_n  (clear_n),
    .load     (accept),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Sequence one access: accept in IDLE, hold the RAM strobe for the latency, pulse done
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ram_re_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mdr_load_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      mdr_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q <= mar_addr;
            if (req_op == OP_WRITE) begin
              wdata_q <= mdr_wdata;
            end
            if (addr_bad) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (req_op == OP_READ) begin
              state_q  <= READ_WAIT;
              ram_re_q <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q  <= WRITE_WAIT;
              ram_we_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end
        READ_WAIT: begin
          if (cnt_zero) begin
            rdata_q    <= ram_rdata;
            ram_re_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            mdr_load_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        WRITE_WAIT: begin
          if (cnt_zero) begin
            ram_we_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_rdata = rdata_q;
  assign mdr_load  = mdr_load_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_re    = ram_re_q;
  assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl with transaction-level model
module tb_mem_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int RL = 2;
  localparam int WL = 1;

  logic          clock = 1'b0;
  logic          clear_n;
  logic          req_read;
  logic          req_write;
  logic [AW-1:0] mar_addr;
  logic [DW-1:0] mdr_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mdr_load;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_re;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic          fault;

  mem_access_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .req_read  (req_read),
    .req_write (req_write),
    .mar_addr  (mar_addr),
    .mdr_wdata (mdr_wdata),
    .mem_rdata (mem_rdata),
    .mdr_load  (mdr_load),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: unwritten words return a fixed address-derived pattern
  function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
    return (a == 9'h004) ? 32'hDEADBEEF : (32'hA500_0000 | {23'h0, a});
  endfunction

  logic [DW-1:0] ram    [0:511];
  bit            ram_wr [0:511];

  always @(posedge clock) begin
    if (ram_we) begin
      ram[ram_addr]    <= ram_wdata;
      ram_wr[ram_addr] <= 1'b1;
    end
  end

  assign ram_rdata = ram_re ? (ram_wr[ram_addr] ? ram[ram_addr] : init_pat(ram_addr)) : '0;

  // Model state: the one outstanding access and what the outputs must show
  int            cyc;
  int            passed;
  int            total;
  logic [DW-1:0] mem_model [0:511];
  bit            acc_valid;
  bit            acc_read;
  bit            acc_bad;
  int            acc_c;
  int            acc_done_c;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_rdata_pend;
  logic          m_fault;

  bit RD_RE   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit RD_DONE [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit WR_WE   [3] = '{1'b1, 1'b0, 1'b0};
  bit WR_DONE [3] = '{1'b0, 1'b1, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    acc_valid    = 1'b0;
    acc_read     = 1'b0;
    acc_bad      = 1'b0;
    acc_c        = 0;
    acc_done_c   = 0;
    m_addr       = '0;
    m_wdata      = '0;
    m_rdata      = '0;
    m_rdata_pend = '0;
    m_fault      = 1'b0;
  endtask

  // One clock: compare all outputs against the model at negedge, record any
  // accepted request, then advance to just after the next rising edge
  task automatic tick();
    int lat;
    bit in_wait;
    bit e_done;
    @(negedge clock);
    if (!clear_n) begin
      model_reset();
      in_wait = 1'b0;
      e_done  = 1'b0;
    end else begin
      lat     = acc_read ? RL : WL;
      in_wait = acc_valid && !acc_bad && (cyc > acc_c) && (cyc <= acc_c + lat);
      e_done  = acc_valid && (cyc == acc_done_c);
      if (e_done && acc_read && !acc_bad) m_rdata = m_rdata_pend;
    end
    chk($sformatf("c%0d_ram_re", cyc),    32'(ram_re),    32'(in_wait && acc_read));
    chk($sformatf("c%0d_ram_we", cyc),    32'(ram_we),    32'(in_wait && !acc_read));
    chk($sformatf("c%0d_busy", cyc),      32'(busy),      32'(in_wait));
    chk($sformatf("c%0d_done", cyc),      32'(done),      32'(e_done));
    chk($sformatf("c%0d_mdr_load", cyc),  32'(mdr_load),  32'(e_done && acc_read && !acc_bad));
    chk($sformatf("c%0d_mem_rdata", cyc), mem_rdata,      m_rdata);
    chk($sformatf("c%0d_ram_addr", cyc),  32'(ram_addr),  32'(m_addr));
    chk($sformatf("c%0d_ram_wdata", cyc), ram_wdata,      m_wdata);
    chk($sformatf("c%0d_fault", cyc),     32'(fault),     32'(m_fault));
    if (clear_n && (!acc_valid || cyc > acc_done_c) && (req_read || req_write)) begin
      acc_valid = 1'b1;
      acc_read  = req_read;
`ifdef MEM_CTRL_ADDR_RANGE_CHECK_EN
      acc_bad   = (mar_addr > 9'h0FF);
`else
      acc_bad   = 1'b0;
`endif
      acc_c      = cyc;
      acc_done_c = acc_bad ? cyc + 1 : cyc + (acc_read ? RL : WL) + 1;
      m_addr     = mar_addr;
      if (!acc_read) m_wdata = mdr_wdata;
      if (acc_bad) m_fault = 1'b1;
      else if (acc_read) m_rdata_pend = mem_model[mar_addr];
      else mem_model[mar_addr] = mdr_wdata;
    end
    @(posedge clock);
    cyc++;
    #2;
  endtask

  initial begin
    cyc       = 0;
    passed    = 0;
    total     = 0;
    clear_n   = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
    mar_addr  = '0;
    mdr_wdata = '0;
    model_reset();
    for (int i = 0; i < 512; i++) mem_model[i] = init_pat(AW'(i));
    @(posedge clock);
    #2;

    // Reset state
    tick();
    tick();
    chk("rst_ram_re", 32'(ram_re), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    clear_n = 1'b1;
    tick();

    // Read 0x004, RL=2: re for 2 cycles, done+mdr_load in the 3rd cycle after sample
    req_read = 1'b1;
    mar_addr = 9'h004;
    tick();
    req_read = 1'b0;
    mar_addr = '0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd_re_%0d", k + 1), 32'(ram_re), 32'(RD_RE[k]));
      chk($sformatf("rd_done_%0d", k + 1), 32'(done), 32'(RD_DONE[k]));
      chk($sformatf("rd_load_%0d", k + 1), 32'(mdr_load), 32'(RD_DONE[k]));
      tick();
    end
    chk("rd_rdata", mem_rdata, 32'hDEADBEEF);

    // Write 0x1FF <- 0x12345678, WL=1; inputs removed after sample to prove latching
    req_write = 1'b1;
    mar_addr  = 9'h1FF;
    mdr_wdata = 32'h12345678;
    tick();
    req_write = 1'b0;
    mar_addr  = '0;
    mdr_wdata = '0;
    chk("wr_addr", 32'(ram_addr), 32'h1FF);
    chk("wr_wdata", ram_wdata, 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wr_we_%0d", k + 1), 32'(ram_we), 32'(WR_WE[k]));
      chk($sformatf("wr_done_%0d", k + 1), 32'(done), 32'(WR_DONE[k]));
      chk($sformatf("wr_load_%0d", k + 1), 32'(mdr_load), 32'd0);
      tick();
    end

    // Read back 0x1FF
    req_read = 1'b1;
    mar_addr = 9'h1FF;
    tick();
    req_read = 1'b0;
    tick();
    tick();
    chk("rb_done", 32'(done), 32'd1);
    chk("rb_rdata", mem_rdata, 32'h12345678);
    tick();

    // Simultaneous read and write: only the read happens
    req_read  = 1'b1;
    req_write = 1'b1;
    mar_addr  = 9'h020;
    mdr_wdata = 32'hCAFEF00D;
    tick();
    req_read  = 1'b0;
    req_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("both_we_%0d", k + 1), 32'(ram_we), 32'd0);
      tick();
    end
    req_read = 1'b1;
    mar_addr = 9'h020;
    tick();
    req_read = 1'b0;
    tick();
    tick();
    chk("both_rdata", mem_rdata, 32'hA5000020);
    tick();

    // Requests while busy are dropped; a held write is taken the IDLE cycle after DONE
    req_read = 1'b1;
    mar_addr = 9'h004;
    tick();
    req_read  = 1'b0;
    req_write = 1'b1;
    mar_addr  = 9'h030;
    mdr_wdata = 32'h0BADF00D;
    tick();
    mar_addr  = 9'h040;
    mdr_wdata = 32'h55AA55AA;
    tick();
    chk("held_we_done", 32'(ram_we), 32'd0);
    tick();
    chk("held_we_idle", 32'(ram_we), 32'd0);
    tick();
    req_write = 1'b0;
    chk("held_we_acc", 32'(ram_we), 32'd1);
    chk("held_addr", 32'(ram_addr), 32'h040);
    tick();
    tick();

    // Reset during the 2nd READ_WAIT cycle aborts the read
    req_read = 1'b1;
    mar_addr = 9'h010;
    tick();
    req_read = 1'b0;
    tick();
    chk("mid_re_before", 32'(ram_re), 32'd1);
    clear_n = 1'b0;
    #1;
    chk("mid_re_async", 32'(ram_re), 32'd0);
    chk("mid_busy_async", 32'(busy), 32'd0);
    tick();
    clear_n   = 1'b1;
    req_write = 1'b1;
    mar_addr  = 9'h011;
    mdr_wdata = 32'h00C0FFEE;
    tick();
    req_write = 1'b0;
    chk("post_rst_we", 32'(ram_we), 32'd1);
    chk("post_rst_done", 32'(done), 32'd0);
    tick();
    tick();
    tick();

`ifdef MEM_CTRL_ADDR_RANGE_CHECK_EN
    // Out-of-range read: sticky fault, no RAM strobe, done the next cycle
    req_read = 1'b1;
    mar_addr = 9'h100;
    tick();
    req_read = 1'b0;
    chk("rng_fault", 32'(fault), 32'd1);
    chk("rng_done", 32'(done), 32'd1);
    chk("rng_re", 32'(ram_re), 32'd0);
    chk("rng_load", 32'(mdr_load), 32'd0);
    tick();
    req_write = 1'b1;
    mar_addr  = 9'h050;
    mdr_wdata = 32'h11112222;
    tick();
    req_write = 1'b0;
    tick();
    tick();
    chk("rng_sticky", 32'(fault), 32'd1);
    clear_n = 1'b0;
    tick();
    chk("rng_cleared", 32'(fault), 32'd0);
    clear_n = 1'b1;
    tick();
`else
    // Without the range check, address 0x100 reaches the RAM
    req_read = 1'b1;
    mar_addr = 9'h100;
    tick();
    req_read = 1'b0;
    chk("norng_re", 32'(ram_re), 32'd1);
    chk("norng_fault", 32'(fault), 32'd0);
    tick();
    tick();
    chk("norng_rdata", mem_rdata, 32'hA5000100);
    tick();
`endif

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
